// File: rtl/tdm_pwm_pkg.sv
// Shared defaults and types for the TDM PWM update scheduler.
package tdm_pwm_pkg;

  localparam int DEF_N_CH   = 16;
  localparam int DEF_IDX_W  = 4;
  localparam int DEF_DATA_W = 64;

  // Owner of the round-robin pointer when both requesters collide.
  typedef enum logic {
    REQ_HOST = 1'b0,
    REQ_SEQ  = 1'b1
  } req_sel_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: a lone requester always wins; on a collision the
// pointer owner wins and ownership passes to the other side.
module rr_arb2
  import tdm_pwm_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic h_valid,
  input  logic s_valid,
  output logic h_grant,
  output logic s_grant
);

  req_sel_e ptr;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the block can leave a value unassigned and infer a latch.
  always_comb begin
    h_grant = 1'b0;
    s_grant = 1'b0;
    if (h_valid && s_valid) begin
      h_grant = (ptr == REQ_HOST);
      s_grant = (ptr == REQ_SEQ);
    end else begin
      h_grant = h_valid;
      s_grant = s_valid;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= REQ_HOST;
    end else if (h_valid && s_valid) begin
      ptr <= (ptr == REQ_HOST) ? REQ_SEQ : REQ_HOST;
    end
  end

endmodule

// File: rtl/tdm_pwm_update_sched.sv
// Coalescing per-channel update scheduler that hands pending duty targets to the
// TDM PWM engine on the exact slot where the engine services each channel.
module tdm_pwm_update_sched
  import tdm_pwm_pkg::*;
#(
  parameter int N_CH   = DEF_N_CH,
  parameter int IDX_W  = DEF_IDX_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              h_valid,
  input  logic [IDX_W-1:0]  h_idx,
  input  logic [DATA_W-1:0] h_data,
  output logic              h_ready,
  input  logic              s_valid,
  input  logic [IDX_W-1:0]  s_idx,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic [IDX_W-1:0]  upd_idx,
  output logic              upd_en,
  output logic [DATA_W-1:0] upd_data,
  output logic [N_CH-1:0]   pend_mask,
  output logic              commit_valid,
  output logic [IDX_W-1:0]  commit_idx
);

  logic [IDX_W-1:0]  slot_idx;
  logic [N_CH-1:0]   pend;
  logic [N_CH-1:0]   pend_next;
  logic [DATA_W-1:0] tgt_table [N_CH];

  logic              wr_en;
  logic [IDX_W-1:0]  wr_idx;
  logic [DATA_W-1:0] wr_data;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .h_valid (h_valid),
    .s_valid (s_valid),
    .h_grant (h_ready),
    .s_grant (s_ready)
  );

  assign wr_en   = h_ready | s_ready;
  assign wr_idx  = h_ready ? h_idx  : s_idx;
  assign wr_data = h_ready ? h_data : s_data;

  assign upd_idx   = slot_idx;
  assign upd_en    = en & pend[slot_idx];
  assign upd_data  = tgt_table[slot_idx];
  assign pend_mask = pend;

  // Commit clears first, then a same-cycle write re-arms the bit: the engine
  // takes the old target now and the new one a full scan later.
  always_comb begin
    pend_next = pend;
    if (upd_en) pend_next[slot_idx] = 1'b0;
    if (wr_en)  pend_next[wr_idx]   = 1'b1;
  end

  // NOTE: the target table is deliberately left without reset; it is only read
  // behind a pending bit, and keeping reset off lets it map to plain storage.
  always_ff @(posedge clk) begin
    if (wr_en) tgt_table[wr_idx] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_idx     <= '0;
      pend         <= '0;
      commit_valid <= 1'b0;
      commit_idx   <= '0;
    end else begin
      if (en) slot_idx <= slot_idx + 1'b1;
      pend         <= pend_next;
      commit_valid <= upd_en;
      if (upd_en) commit_idx <= slot_idx;
    end
  end

endmodule

// File: tb/tb_tdm_pwm_update_sched.sv
// Randomized bench with a behavioural channel model and a commit scoreboard.
module tb_tdm_pwm_update_sched;
  import tdm_pwm_pkg::*;

  logic        clk = 1'b0;
  logic        rst, en;
  logic        h_valid, s_valid, h_ready, s_ready;
  logic [3:0]  h_idx, s_idx, upd_idx, commit_idx;
  logic [63:0] h_data, s_data, upd_data;
  logic        upd_en, commit_valid;
  logic [15:0] pend_mask;

  always #5 clk = ~clk;

  tdm_pwm_update_sched dut (
    .clk(clk), .rst(rst), .en(en),
    .h_valid(h_valid), .h_idx(h_idx), .h_data(h_data), .h_ready(h_ready),
    .s_valid(s_valid), .s_idx(s_idx), .s_data(s_data), .s_ready(s_ready),
    .upd_idx(upd_idx), .upd_en(upd_en), .upd_data(upd_data),
    .pend_mask(pend_mask), .commit_valid(commit_valid), .commit_idx(commit_idx)
  );

  typedef struct {
    logic [3:0]  idx;
    logic [63:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] latched_q[$];

  int checks   = 0;
  int failures = 0;
  bit started  = 0;

  // Reference model: scan position, per-channel pending flag and latest value.
  int          m_slot;
  bit          m_pend[16];
  logic [63:0] m_tab[16];
  bit          m_seq_turn;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_slot     = 0;
    m_seq_turn = 0;
    for (int i = 0; i < 16; i++) m_pend[i] = 0;
  endfunction

  task automatic step(input bit r, input bit e,
                      input bit hv, input logic [3:0] hi, input logic [63:0] hd,
                      input bit sv, input logic [3:0] si, input logic [63:0] sd);
    bit          gh, gs, exp_upd;
    logic [15:0] pm;
    exp_t        ex;
    @(negedge clk);
    rst = r; en = e;
    h_valid = hv; h_idx = hi; h_data = hd;
    s_valid = sv; s_idx = si; s_data = sd;
    #1;
    gh      = hv && (!sv || !m_seq_turn);
    gs      = sv && (!hv || m_seq_turn);
    exp_upd = e && m_pend[m_slot];
    for (int i = 0; i < 16; i++) pm[i] = m_pend[i];
    check("h_ready", h_ready, gh);
    check("s_ready", s_ready, gs);
    check("upd_idx", upd_idx, m_slot[3:0]);
    check("upd_en", upd_en, exp_upd);
    check("pend_mask", pend_mask, pm);
    if (exp_upd) check("upd_data", upd_data, m_tab[m_slot]);
    if (r) begin
      model_reset();
    end else begin
      if (exp_upd) begin
        ex.idx  = m_slot[3:0];
        ex.data = m_tab[m_slot];
        exp_q.push_back(ex);
        m_pend[m_slot] = 0;
      end
      if (gh) begin m_tab[hi] = hd; m_pend[hi] = 1; end
      if (gs) begin m_tab[si] = sd; m_pend[si] = 1; end
      if (hv && sv) m_seq_turn = !m_seq_turn;
      if (e) m_slot = (m_slot + 1) % 16;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 1, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic wait_slot(input int target);
    for (int i = 0; i < 16 && m_slot != target; i++) idle(1);
    check("wait_slot", m_slot[3:0], target[3:0]);
  endtask

  // Monitor: pairs each commit pulse with the value the engine latched a cycle earlier.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!started) continue;
      if (commit_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("commit_unexpected", commit_valid, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("commit_idx", commit_idx, e.idx);
          if (latched_q.size() > 0) check("commit_data", latched_q.pop_front(), e.data);
          else check("commit_no_latch", latched_q.size(), 1);
        end
      end
      if (upd_en === 1'b1 && rst === 1'b0) latched_q.push_back(upd_data);
    end
  end

  initial begin
    rst = 1; en = 0;
    h_valid = 0; h_idx = 0; h_data = 0;
    s_valid = 0; s_idx = 0; s_data = 0;
    repeat (3) @(negedge clk);
    model_reset();
    started = 1;
    check("reset_commit_valid", commit_valid, 1'b0);
    check("reset_commit_idx", commit_idx, 4'd0);

    // Idle scan after reset: nothing pending, index walks 0..15 and wraps.
    idle(20);

    // Host write ch5 while the scan is at slot 2.
    wait_slot(2);
    step(0, 1, 1, 4'd5, 64'h40, 0, 0, 0);
    idle(20);

    // Collision on ch3/ch9 for four cycles with the pointer at host.
    for (int i = 0; i < 4; i++)
      step(0, 1, 1, 4'd3, 64'h300 + 64'(i), 1, 4'd9, 64'h900 + 64'(i));
    idle(20);

    // Two host writes to ch7 before its slot: only the later value commits.
    wait_slot(8);
    step(0, 1, 1, 4'd7, 64'h10, 0, 0, 0);
    step(0, 1, 1, 4'd7, 64'h20, 0, 0, 0);
    idle(20);

    // Write ch4 on the same cycle its old target commits.
    wait_slot(0);
    step(0, 1, 1, 4'd4, 64'h11, 0, 0, 0);
    wait_slot(4);
    step(0, 1, 1, 4'd4, 64'h99, 0, 0, 0);
    idle(34);

    // en low: writes still accepted, scan frozen, no commits.
    for (int i = 0; i < 10; i++)
      step(0, 0, 1, 4'($urandom_range(15)), {$urandom, $urandom},
           1, 4'($urandom_range(15)), {$urandom, $urandom});
    idle(5);

    // Reset mid-scan with pending bits set.
    for (int i = 0; i < 3; i++)
      step(0, 1, 1, 4'($urandom_range(15)), {$urandom, $urandom}, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0, 0);
    idle(20);

    // Randomized traffic with occasional en drops and resets.
    for (int i = 0; i < 2000; i++)
      step($urandom_range(199) == 0, $urandom_range(9) < 8,
           $urandom_range(1), 4'($urandom_range(15)), {$urandom, $urandom},
           $urandom_range(1), 4'($urandom_range(15)), {$urandom, $urandom});

    idle(20);
    @(negedge clk);
    #3;
    check("drain_expected", exp_q.size(), 0);
    check("drain_latched", latched_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tdm_pwm_update_sched.md
Name: tdm_pwm_update_sched

Overview:
Front-end scheduler for the 16-channel time-division-multiplexed PWM engine. It accepts duty-target writes from two requesters (host register port and fade sequencer) and arbitrates them round-robin. Writes are stored per channel in a coalescing pending table. Each pending target is presented to the engine's update_idx/update_en/target_in port on the exact slot where the engine services that channel. A scan-index mirror runs in lockstep with the engine's internal slot counter.

Parameters:
N_CH, 16, number of PWM channels; power of two; must equal the engine's channel count
IDX_W, 4, channel index width, equal to log2(N_CH)
DATA_W, 64, duty target width; must match the engine's target_in width

Ports:
clk  in  1  system clock, shared with the PWM engine
rst  in  1  synchronous active-high reset
en  in  1  slot-advance enable; the same net that drives the engine's en
h_valid  in  1  host write request
h_idx  in  IDX_W  host target channel
h_data  in  DATA_W  host duty target
h_ready  out  1  host request accepted this cycle
s_valid  in  1  sequencer write request
s_idx  in  IDX_W  sequencer target channel
s_data  in  DATA_W  sequencer duty target
s_ready  out  1  sequencer request accepted this cycle
upd_idx  out  IDX_W  drives engine update_idx; equals the mirror slot index
upd_en  out  1  drives engine update_en
upd_data  out  DATA_W  drives engine target_in
pend_mask  out  N_CH  per-channel pending flags
commit_valid  out  1  registered pulse: one target committed to the engine
commit_idx  out  IDX_W  channel committed; valid while commit_valid=1

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, on port rst. At top level the engine's rst_n is driven from ~rst, so both blocks leave reset on the same edge.
- Reset values: slot index mirror=0, pend_mask=0, round-robin pointer=host, commit_valid=0, commit_idx=0. The target table is not reset; it is only read when its pending bit is set.
- Mirror: slot_idx increments modulo N_CH on every cycle with en=1, and holds when en=0. upd_idx=slot_idx, combinational.
- Arbitration, combinational ready:
  - Only one valid → that requester is granted.
  - Both valid → the pointer's owner is granted, and the pointer flips to the other requester after the grant.
  - No valid → pointer holds.
  - Exactly one of h_ready/s_ready is high per grant.
  - Same-channel collisions are not merged; the loser retries next cycle.
- Accept: on a granted handshake (valid & ready), table[idx] <= data and pend[idx] <= 1, effective the next cycle. A second write to an already-pending channel overwrites the target (last write wins). No backpressure beyond arbitration.
- Presentation: upd_en = en & pend[slot_idx]; upd_data = table[slot_idx]; both combinational from registered state.
- Commit: when upd_en=1, the engine latches upd_data at that edge. pend[slot_idx] clears, commit_valid=1 and commit_idx=slot_idx on the following cycle. Otherwise commit_valid=0.
- Write and commit to the same channel in the same cycle: the engine receives the old table value. The new data is written and pend stays 1, so the new value commits one full scan later.
- Latency: a write accepted in cycle N is eligible from cycle N+1. It commits within N_CH en-cycles of N+1, on the first en-cycle where slot_idx equals its channel.
- en=0: nothing commits and the slot index holds; writes are still accepted.
- Reset mid-operation: all pending writes are discarded and no commit pulse is emitted. The mirror restarts at 0 in step with the engine.

Decomposition:
- Package tdm_pwm_pkg holds N_CH, IDX_W and DATA_W defaults, plus the enum req_sel_e {REQ_HOST, REQ_SEQ} used for the pointer.
- Sub-module rr_arb2: 2-way round-robin arbiter with valid inputs, grant outputs and internal pointer.
- The table and pending bits stay in the top module as an N_CH x DATA_W register file.

Test Plan:
- Reset, then en=1 continuously: pend_mask=0, upd_en never asserts, and upd_idx cycles 0..15..0.
- Host writes ch5=64'h40 while slot_idx=2: pend_mask[5]=1 next cycle. upd_en=1 with upd_data=64'h40 when slot_idx=5. commit_valid=1 with commit_idx=5 one cycle later, and pend_mask[5]=0.
- Host and sequencer both valid (ch3 and ch9) for 4 cycles, pointer=host: grants alternate H,S,H,S. Both channels commit on their slots, and the final table values are the last granted data for each.
- Two host writes to ch7 (0x10, then 0x20) before slot 7: exactly one commit with upd_data=0x20.
- Write ch4=0x99 in the same cycle its slot commits pending 0x11: the engine gets 0x11, pend[4] stays 1, and 0x99 commits 16 en-cycles later.
- en=0 for 10 cycles with writes: ready stays asserted, no commits occur, slot_idx is frozen. Assert rst mid-scan with pending bits set: pend_mask=0 and slot_idx=0 the next cycle, and no commit pulse.
